stream_checker: RTL

Self-checking sink for one `arf` output port; it takes the place of a bench `consumer`. It requests tokens over the req/ack handshake and captures `din` on every ack. Each token is compared against an affine golden sequence (expected = MUL·k + ADD for token k). The block counts matches and mismatches, latches the first failure, watches for stalled producers, and raises `done` after `MAX_TOKENS` tokens.

---
 rtl/stream_checker_pkg.sv | 28 ++
 rtl/stream_checker_lfsr16.sv | 25 ++
 rtl/stream_checker.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/stream_checker_pkg.sv
// Shared types and widths for the stream checker and its LFSR.
package stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned PERR_W  = 16;
  localparam int unsigned IDX_W   = 32;
  localparam int unsigned WD_W    = 32;
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned PCT_MOD = 100;
  localparam int unsigned DRAW_W  = 7;
  localparam int unsigned CMP_W   = 8;

  // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Reduce an LFSR value to a percent draw in 0..99
  function automatic logic [DRAW_W-1:0] pct_draw(input logic [LFSR_W-1:0] v);
    return DRAW_W'(v % LFSR_W'(PCT_MOD));
  endfunction

endpackage

// File: rtl/stream_checker_lfsr16.sv
// Free-running 16-bit Galois LFSR providing a percent draw for stall decisions.
module lfsr16
  import stream_checker_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DRAW_W-1:0] draw_c
);

  logic [LFSR_W-1:0] value;

  // Shift right every cycle, folding the dropped bit back through the taps
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_W'(SEED);
    end else begin
      value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

  assign draw_c = pct_draw(value);

endmodule

// File: rtl/stream_checker.sv
// Self-checking stream sink: requests tokens, compares against an affine
// golden sequence, counts results and watches for protocol errors and stalls.
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL        = 3,
  parameter int unsigned ADD        = 2,
  parameter int unsigned MAX_TOKENS = 5000,
  parameter int unsigned STALL_RATE = 0,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [31:0] SEED       = 32'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  req,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [CNT_W-1:0]      match_count,
  output logic [CNT_W-1:0]      mismatch_count,
  output logic [PERR_W-1:0]     proto_err_count,
  output logic [IDX_W-1:0]      first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  err,
  output logic                  timeout,
  output logic                  done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_TOKENS - 1);
  localparam logic [CMP_W-1:0] STALL_LIM = CMP_W'(STALL_RATE);
  localparam bit               WD_EN     = (TIMEOUT != 0);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  state_t                  state;
  state_t                  state_next;
  logic                    req_next;
  logic                    accept_c;
  logic                    proto_c;
  logic                    mism_c;
  logic                    last_c;
  logic                    stall_c;
  logic                    wd_hit_c;
  logic [DRAW_W-1:0]       draw_c;
  logic [IDX_W-1:0]        k;
  logic [DATA_WIDTH-1:0]   expected;
  logic [WD_W-1:0]         wd_cnt;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .draw_c(draw_c)
  );

  assign accept_c = (state == WAIT) && ack;
  assign proto_c  = (state != WAIT) && ack;
  assign mism_c   = accept_c && (din != expected);
  assign last_c   = (k == LAST_IDX);
  // Borrow out of draw - limit means draw < STALL_RATE
  assign stall_c  = 1'(((CMP_W+1)'(draw_c) - (CMP_W+1)'(STALL_LIM)) >> CMP_W);
  assign wd_hit_c = WD_EN && (state == WAIT) && !ack && (wd_cnt == WD_LAST);

  // FSM state and registered request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      req   <= req_next;
    end
  end

  // Next state and request; req drops on every sampled ack
  always_comb begin
    state_next = state;
    req_next   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = WAIT;
          req_next   = 1'b1;
        end
      end
      WAIT: begin
        if (ack) begin
          if (last_c)       state_next = FIN;
          else if (stall_c) state_next = GAP;
          else              state_next = WAIT;
        end else if (!en) begin
          state_next = IDLE;
        end else begin
          req_next = 1'b1;
        end
      end
      GAP:     state_next = WAIT;
      FIN:     state_next = FIN;
      default: state_next = IDLE;
    endcase
  end

  // Token index and golden accumulator, modulo 2^DATA_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      expected <= DATA_WIDTH'(ADD);
    end else if (accept_c) begin
      if (k != '1) k <= k + IDX_W'(1);
      expected <= expected + DATA_WIDTH'(MUL);
    end
  end

  // Saturating match/mismatch counters
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count    <= '0;
      mismatch_count <= '0;
    end else if (accept_c) begin
      if (!mism_c) begin
        if (match_count != '1) match_count <= match_count + CNT_W'(1);
      end else begin
        if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
      end
    end
  end

  // Capture index and data of the first mismatching token
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (mism_c && (mismatch_count == '0)) begin
      first_err_idx  <= k;
      first_err_data <= din;
    end
  end

  // Saturating count of acks arriving outside WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_count <= '0;
    end else if (proto_c && (proto_err_count != '1)) begin
      proto_err_count <= proto_err_count + PERR_W'(1);
    end
  end

  // Watchdog: cycles spent in WAIT since entry or last ack
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state != WAIT) || ack) begin
      wd_cnt <= '0;
    end else if (wd_cnt != '1) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Sticky status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      timeout <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (mism_c || proto_c || wd_hit_c) err <= 1'b1;
      if (wd_hit_c) timeout <= 1'b1;
      if (accept_c && last_c) done <= 1'b1;
    end
  end

endmodule
